placar_multi: RTL and testbench
===============================

PLACAR_MULTI -- requirements
Module: placar_multi

Parameters
REQ-001 N_TEAMS, 2, number of independent score registers (1..4).
REQ-002 SCORE_MAX, 199, saturation ceiling of each score (100..999).
REQ-003 SHOT_A, 14, shot-clock preset selected by shot_sel=0 (1..99).
REQ-004 SHOT_B, 24, shot-clock preset selected by shot_sel=1 (1..99).
REQ-005 TICK_DIV, 50_000_000, clk cycles per shot-clock second (>=2).
REQ-006 REFRESH_DIV, 50_000, clk cycles each display digit is enabled (>=1).

Interface
REQ-007 clk  in  1  board clock; the only clock; all state changes on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 btn  in  3  point buttons, active-high levels; btn[0]=1 pt, btn[1]=2 pt, btn[2]=3 pt; synchronous to clk.
REQ-010 sinal  in  1  0 = add, 1 = subtract.
REQ-011 team_sel  in  max(1,clog2(N_TEAMS))  team targeted by buttons and shown on display.
REQ-012 shot_sel  in  1  preset choice: 0 = SHOT_A, 1 = SHOT_B.
REQ-013 resetar  in  1  level; reloads the shot clock.
REQ-014 pause  in  1  1 = shot clock runs, 0 = frozen.
REQ-015 saida  out  7  segments a..g on saida[0..6], active-low.
REQ-016 blocos  out  4  digit enables, active-low, exactly one low at a time.
REQ-017 alerta  out  1  high while any team score > 99.
REQ-018 expirou  out  1  high while shot clock = 0.

Function
REQ-019 Score registers SHALL be clog2(SCORE_MAX+1) bits wide, unsigned, one per team.
REQ-020 A press SHALL be an edge where btn has exactly one bit high and the registered previous btn is 000; any other pattern, including multi-bit presses, is ignored.
REQ-021 On a press, the score of team_sel SHALL update at that same edge: +pts with saturation at SCORE_MAX, or -pts with saturation at 0; other teams are unchanged.
REQ-022 A held button SHALL count once; a new press requires btn to return to 000 first.
REQ-023 team_sel >= N_TEAMS SHALL block score updates and display score 00.
REQ-024 The tick prescaler SHALL count 0..TICK_DIV-1 while pause=1, emit a 1-cycle tick at the wrap, and hold its value while pause=0.
REQ-025 On a tick with shot clock > 0, the shot clock SHALL decrement by 1; at 0 it holds, and expirou=1.
REQ-026 resetar=1 SHALL load the preset chosen by shot_sel and clear the prescaler at that edge; it overrides a coincident tick; expirou falls the cycle after the load.
REQ-027 A change of shot_sel SHALL take effect only at the next resetar or reset.
REQ-028 The refresh counter SHALL advance the digit index 0->1->2->3->0 every REFRESH_DIV cycles, free-running and independent of pause.
REQ-029 Digit mapping SHALL be: 0 = score tens, 1 = score units, 2 = shot tens, 3 = shot units; blocos[i]=0 for the active index.
REQ-030 Displayed score digits SHALL be (score mod 100) in BCD, decoded to 7 segments, and registered together with blocos so that both change on the same edge.
REQ-031 alerta SHALL be a registered compare, valid one cycle after the score change.

Reset
REQ-032 At reset=1, every score SHALL be 0, the shot clock SHALL be loaded with the preset for the current shot_sel, and the prescaler, refresh counter, digit index and previous-btn register SHALL be 0.
REQ-033 During and after reset, the outputs SHALL be: blocos=1110, saida = segments of "0", alerta=0, expirou=0.
REQ-034 Reset SHALL take priority over all other inputs, including a press or resetar in the same cycle.

Verification (TICK_DIV=4, REFRESH_DIV=2, N_TEAMS=2)
REQ-035 Scenario 1: team 0, add, press 3 pt then 2 pt -> score0=5 after the second press edge; score1=0; alerta=0.
REQ-036 Scenario 2: score0=98, add 3 pt -> 101 and alerta=1 one cycle later; display digits show 0,1; subtract 2 pt -> 99 and alerta=0.
REQ-037 Scenario 3: score0=198, add 3 pt -> 199 (saturated); score0=1, subtract 3 pt -> 0.
REQ-038 Scenario 4: shot_sel=0, pause=1 for 56 cycles after reset -> shot clock 0 and expirou=1; 8 more cycles -> still 0; resetar with shot_sel=1 -> 24 and expirou=0 next cycle.
REQ-039 Scenario 5: btn=011 pressed, or btn held high for 20 cycles -> no update for 011, exactly one update for the held button; pause=0 -> shot clock and prescaler frozen.
REQ-040 Scenario 6: reset asserted mid-count with score0=50 -> next cycle score0=0, shot clock = preset, blocos=1110, and blocos then rotates every 2 cycles.

Source files
------------

// File: rtl/placar_multi.sv
// Multi-team scoreboard: saturating per-team scores driven by point buttons,
// a shot clock with selectable preset, and a 4-digit multiplexed 7-segment display.

// One team's score register with saturating add/subtract.
module placar_score_lane #(
  parameter int SW        = 8,
  parameter int SCORE_MAX = 199
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hit,
  input  logic          sub,
  input  logic [1:0]    pts,
  output logic [SW-1:0] score
);
  logic [SW:0]   sum;
  logic [SW-1:0] pts_w;

  // Widen the point value and form the unsaturated sum one bit wider than the score.
  always_comb begin
    pts_w = {{(SW-2){1'b0}}, pts};
    sum   = {1'b0, score} + {1'b0, pts_w};
  end

  // Saturate at SCORE_MAX on add and at zero on subtract.
  always_ff @(posedge clk) begin
    if (reset)
      score <= '0;
    else if (hit) begin
      if (sub)
        score <= (score < pts_w) ? '0 : score - pts_w;
      else
        score <= (sum > (SW+1)'(SCORE_MAX)) ? SW'(SCORE_MAX) : sum[SW-1:0];
    end
  end
endmodule

module placar_multi #(
  parameter int N_TEAMS     = 2,
  parameter int SCORE_MAX   = 199,
  parameter int SHOT_A      = 14,
  parameter int SHOT_B      = 24,
  parameter int TICK_DIV    = 50_000_000,
  parameter int REFRESH_DIV = 50_000
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [2:0]                             btn,
  input  logic                                   sinal,
  input  logic [(N_TEAMS>1?$clog2(N_TEAMS):1)-1:0] team_sel,
  input  logic                                   shot_sel,
  input  logic                                   resetar,
  input  logic                                   pause,
  output logic [6:0]                             saida,
  output logic [3:0]                             blocos,
  output logic                                   alerta,
  output logic                                   expirou
);
  localparam int TW = (N_TEAMS > 1) ? $clog2(N_TEAMS) : 1;
  localparam int SW = $clog2(SCORE_MAX + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] PRE_A = 7'(SHOT_A);
  localparam logic [6:0] PRE_B = 7'(SHOT_B);

  // Active-low segments, bit 0 = a .. bit 6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0: p = 7'h3F;
      4'd1: p = 7'h06;
      4'd2: p = 7'h5B;
      4'd3: p = 7'h4F;
      4'd4: p = 7'h66;
      4'd5: p = 7'h6D;
      4'd6: p = 7'h7D;
      4'd7: p = 7'h07;
      4'd8: p = 7'h7F;
      4'd9: p = 7'h6F;
      default: p = 7'h00;
    endcase
    return ~p;
  endfunction

  logic [2:0]                   btn_prev;
  logic                         press;
  logic [1:0]                   pts;
  logic [N_TEAMS-1:0][SW-1:0]   score;
  logic [SW-1:0]                sel_score;
  logic                         over;
  logic [PW-1:0]                presc;
  logic                         tick;
  logic [6:0]                   shot, shot_d;
  logic [RW-1:0]                rcnt;
  logic [1:0]                   dig;
  logic [9:0]                   s100;
  logic [3:0]                   sc_t, sc_u, sh_t, sh_u, dval;

  // A press is a single button rising out of an all-released state.
  always_comb begin
    press = (btn_prev == 3'b000) &&
            ((btn == 3'b001) || (btn == 3'b010) || (btn == 3'b100));
    pts   = btn[0] ? 2'd1 : (btn[1] ? 2'd2 : 2'd3);
  end

  // Remember the last button pattern so a held button counts once.
  always_ff @(posedge clk) begin
    if (reset) btn_prev <= 3'b000;
    else       btn_prev <= btn;
  end

  // Out-of-range team_sel matches no lane, so updates are blocked.
  for (genvar t = 0; t < N_TEAMS; t++) begin : g_lane
    placar_score_lane #(.SW(SW), .SCORE_MAX(SCORE_MAX)) u_lane (
      .clk   (clk),
      .reset (reset),
      .hit   (press && (team_sel == TW'(t))),
      .sub   (sinal),
      .pts   (pts),
      .score (score[t])
    );
  end

  // Select the displayed team's score (00 when none matches) and flag >99.
  always_comb begin
    sel_score = '0;
    over      = 1'b0;
    for (int t = 0; t < N_TEAMS; t++) begin
      if (team_sel == TW'(t)) sel_score = score[t];
      if (score[t] > SW'(99)) over = 1'b1;
    end
  end

  // Registered compare so alerta follows a score change by one cycle.
  always_ff @(posedge clk) begin
    if (reset) alerta <= 1'b0;
    else       alerta <= over;
  end

  // Shot-clock next value: reload wins over a coincident tick; holds at zero.
  always_comb begin
    tick   = pause && (presc == PW'(TICK_DIV - 1));
    shot_d = shot;
    if (resetar)                    shot_d = shot_sel ? PRE_B : PRE_A;
    else if (tick && shot != 7'd0)  shot_d = shot - 7'd1;
  end

  // Prescaler, shot clock and expiry flag (flag tracks the value being loaded).
  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      shot    <= shot_sel ? PRE_B : PRE_A;
      expirou <= 1'b0;
    end else begin
      shot    <= shot_d;
      expirou <= (shot_d == 7'd0);
      if (resetar)    presc <= '0;
      else if (pause) presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // BCD split of the displayed score (mod 100) and the shot clock.
  always_comb begin
    s100 = 10'(sel_score) % 10'd100;
    sc_t = 4'(s100 / 10'd10);
    sc_u = 4'(s100 % 10'd10);
    sh_t = 4'(shot / 7'd10);
    sh_u = 4'(shot % 7'd10);
    case (dig)
      2'd0:    dval = sc_t;
      2'd1:    dval = sc_u;
      2'd2:    dval = sh_t;
      default: dval = sh_u;
    endcase
  end

  // Free-running digit scan; segments and enables registered on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt   <= '0;
      dig    <= 2'd0;
      blocos <= 4'b1110;
      saida  <= seg7(4'd0);
    end else begin
      if (rcnt == RW'(REFRESH_DIV - 1)) begin
        rcnt <= '0;
        dig  <= dig + 2'd1;
      end else begin
        rcnt <= rcnt + RW'(1);
      end
      blocos <= ~(4'b0001 << dig);
      saida  <= seg7(dval);
    end
  end
endmodule

// File: tb/tb_placar_multi.sv
// Randomized and directed bench for placar_multi against a cycle-level score/shot model.
module tb_placar_multi;
  localparam int NT = 2;
  localparam int SMAX = 199;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] btn = 3'b000;
  logic       sinal = 1'b0;
  logic [0:0] team_sel = 1'b0;
  logic       shot_sel = 1'b0;
  logic       resetar = 1'b0;
  logic       pause = 1'b0;
  logic [6:0] saida;
  logic [3:0] blocos;
  logic       alerta, expirou;

  placar_multi #(.N_TEAMS(NT), .SCORE_MAX(SMAX), .SHOT_A(14), .SHOT_B(24),
                 .TICK_DIV(4), .REFRESH_DIV(2)) dut (
    .clk(clk), .reset(reset), .btn(btn), .sinal(sinal), .team_sel(team_sel),
    .shot_sel(shot_sel), .resetar(resetar), .pause(pause),
    .saida(saida), .blocos(blocos), .alerta(alerta), .expirou(expirou));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference state
  int sc[NT];
  int shot = 14;
  int presc = 0;
  int prev = 0;
  int e = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    logic [6:0] p;
    case (d)
      0: p = 7'h3F; 1: p = 7'h06; 2: p = 7'h5B; 3: p = 7'h4F; 4: p = 7'h66;
      5: p = 7'h6D; 6: p = 7'h7D; 7: p = 7'h07; 8: p = 7'h7F; 9: p = 7'h6F;
      default: p = 7'h00;
    endcase
    return ~p;
  endfunction

  // One clock: predict the edge from the applied inputs, advance, then compare.
  task automatic cyc();
    int idx, val, s, ts, pts;
    bit ea;
    logic [3:0] eb;
    ts = int'(team_sel);
    s  = (ts < NT) ? sc[ts] : 0;
    idx = reset ? 0 : (e / 2) % 4;
    case (idx)
      0: val = (s % 100) / 10;
      1: val = s % 10;
      2: val = shot / 10;
      default: val = shot % 10;
    endcase
    if (reset) val = 0;
    ea = 1'b0;
    if (reset) begin
      foreach (sc[t]) sc[t] = 0;
      shot = shot_sel ? 24 : 14;
      presc = 0; prev = 0; e = 0;
    end else begin
      foreach (sc[t]) if (sc[t] > 99) ea = 1'b1;
      if (prev == 0 && (btn == 3'd1 || btn == 3'd2 || btn == 3'd4) && ts < NT) begin
        pts = (btn == 3'd1) ? 1 : (btn == 3'd2) ? 2 : 3;
        if (sinal) sc[ts] = (sc[ts] < pts) ? 0 : sc[ts] - pts;
        else       sc[ts] = (sc[ts] + pts > SMAX) ? SMAX : sc[ts] + pts;
      end
      prev = int'(btn);
      if (resetar) begin
        shot = shot_sel ? 24 : 14;
        presc = 0;
      end else if (pause) begin
        presc++;
        if (presc == 4) begin
          presc = 0;
          if (shot > 0) shot--;
        end
      end
      e++;
    end
    @(posedge clk);
    @(negedge clk);
    eb = ~(4'b0001 << idx);
    chk("blocos", blocos, eb);
    chk("saida", saida, seg(val));
    chk("alerta", alerta, ea);
    chk("expirou", expirou, shot == 0);
  endtask

  task automatic press(input int p, input bit sub, input int t);
    btn = 3'(1 << (p - 1));
    sinal = sub;
    team_sel = 1'(t);
    cyc();
    btn = 3'b000;
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1; btn = 3'b000; resetar = 1'b0; pause = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  // Scan all four digits and compare against fixed expected values (esh<0 skips shot).
  task automatic scene(input string tag, input int es, input int esh);
    int d;
    btn = 3'b000; pause = 1'b0; resetar = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      case (blocos)
        4'b1110: d = (es % 100) / 10;
        4'b1101: d = es % 10;
        4'b1011: d = (esh < 0) ? -1 : esh / 10;
        4'b0111: d = (esh < 0) ? -1 : esh % 10;
        default: d = -1;
      endcase
      if (d >= 0) chk(tag, saida, seg(d));
    end
  endtask

  initial begin
    foreach (sc[t]) sc[t] = 0;
    // reset state
    for (int i = 0; i < 3; i++) cyc();
    chk("rst_blocos", blocos, 4'b1110);
    chk("rst_saida", saida, 7'b1000000);
    chk("rst_alerta", alerta, 1'b0);
    chk("rst_expirou", expirou, 1'b0);
    reset = 1'b0;

    // scenario 1
    press(3, 0, 0);
    press(2, 0, 0);
    scene("s1_t0", 5, 14);
    team_sel = 1'b1;
    scene("s1_t1", 0, 14);
    chk("s1_alerta", alerta, 1'b0);

    // scenario 2
    do_reset();
    for (int i = 0; i < 32; i++) press(3, 0, 0);
    press(2, 0, 0);
    scene("s2_98", 98, 14);
    press(3, 0, 0);
    chk("s2_alerta_hi", alerta, 1'b1);
    scene("s2_101", 101, 14);
    press(2, 1, 0);
    chk("s2_alerta_lo", alerta, 1'b0);
    scene("s2_99", 99, 14);

    // scenario 3
    do_reset();
    for (int i = 0; i < 66; i++) press(3, 0, 0);
    press(3, 0, 0);
    scene("s3_sat", 199, 14);
    for (int i = 0; i < 66; i++) press(3, 1, 0);
    scene("s3_one", 1, 14);
    press(3, 1, 0);
    scene("s3_zero", 0, 14);

    // scenario 4
    shot_sel = 1'b0;
    do_reset();
    pause = 1'b1;
    for (int i = 0; i < 56; i++) cyc();
    chk("s4_expirou", expirou, 1'b1);
    scene("s4_zero", 0, 0);
    pause = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    chk("s4_hold", expirou, 1'b1);
    scene("s4_hold0", 0, 0);
    shot_sel = 1'b1; resetar = 1'b1;
    cyc();
    resetar = 1'b0;
    chk("s4_reload", expirou, 1'b0);
    scene("s4_24", 0, 24);

    // scenario 5
    btn = 3'b011; cyc(); cyc();
    btn = 3'b000; cyc();
    scene("s5_multi", 0, 24);
    btn = 3'b001; sinal = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    btn = 3'b000; cyc();
    scene("s5_held", 1, 24);
    pause = 1'b1; for (int i = 0; i < 3; i++) cyc();
    pause = 1'b0; for (int i = 0; i < 10; i++) cyc();
    scene("s5_frozen", 1, 24);
    pause = 1'b1; cyc();
    scene("s5_tick", 1, 23);

    // scenario 6
    do_reset();
    for (int i = 0; i < 16; i++) press(3, 0, 0);
    press(2, 0, 0);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    reset = 1'b1; btn = 3'b001;
    cyc();
    chk("s6_blocos", blocos, 4'b1110);
    chk("s6_alerta", alerta, 1'b0);
    reset = 1'b0; btn = 3'b000;
    scene("s6_clear", 0, 24);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      btn      = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      sinal    = ($urandom_range(0, 3) == 0);
      team_sel = 1'($urandom);
      pause    = ($urandom_range(0, 3) != 0);
      resetar  = ($urandom_range(0, 29) == 0);
      shot_sel = 1'($urandom);
      reset    = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
